llc_hc_arbiter: RTL and testbench



---
 rtl/llc_hc_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_llc_hc_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_hc_arbiter.sv
// llc_hc_arbiter: two-port round-robin request arbiter and response router
// in front of the LLC hc_* port. Define LLC_ARB_STATS_EN for per-port grant counters.

module llc_hc_arbiter #(
    parameter int PADDR_BITS = 19,
    parameter int W          = 64,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  p0_valid_in,
    output logic                  p0_ready_out,
    input  logic [PADDR_BITS-1:0] p0_addr_in,
    input  logic [W-1:0]          p0_value_in,
    input  logic                  p0_we_in,
    input  logic                  p1_valid_in,
    output logic                  p1_ready_out,
    input  logic [PADDR_BITS-1:0] p1_addr_in,
    input  logic [W-1:0]          p1_value_in,
    input  logic                  p1_we_in,
    output logic                  p0_valid_out,
    input  logic                  p0_ready_in,
    output logic [PADDR_BITS-1:0] p0_addr_out,
    output logic [W-1:0]          p0_value_out,
    output logic                  p1_valid_out,
    input  logic                  p1_ready_in,
    output logic [PADDR_BITS-1:0] p1_addr_out,
    output logic [W-1:0]          p1_value_out,
    output logic                  hc_valid_out,
    input  logic                  hc_ready_in,
    output logic [PADDR_BITS-1:0] hc_addr_out,
    output logic [W-1:0]          hc_value_out,
    output logic                  hc_we_out,
    input  logic                  hc_valid_in,
    output logic                  hc_ready_out,
    input  logic [PADDR_BITS-1:0] hc_addr_in,
    input  logic [W-1:0]          hc_value_in
`ifdef LLC_ARB_STATS_EN
    ,
    output logic [31:0]           p0_grants_out,
    output logic [31:0]           p1_grants_out
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        RETURN
    } state_t;

    state_t state, state_nx;
    logic   owner, owner_nx;
    logic   last_grant;
    logic   grant, gnt_port;

    logic [PADDR_BITS-1:0] in_addr  [2];
    logic [W-1:0]          in_value [2];
    logic                  in_we    [2];
    logic                  in_valid [2];

    logic [PADDR_BITS-1:0] mem_addr  [2][DEPTH];
    logic [W-1:0]          mem_value [2][DEPTH];
    logic                  mem_we    [2][DEPTH];

    logic [AW:0] wr_ptr [2];
    logic [AW:0] rd_ptr [2];
    logic [AW:0] count  [2];
    logic        push   [2];
    logic        pop    [2];
    logic        nempty [2];
    logic        fifo_rdy [2];

    logic [PADDR_BITS-1:0] rsp_addr;
    logic [W-1:0]          rsp_value;

    assign in_addr[0]  = p0_addr_in;
    assign in_addr[1]  = p1_addr_in;
    assign in_value[0] = p0_value_in;
    assign in_value[1] = p1_value_in;
    assign in_we[0]    = p0_we_in;
    assign in_we[1]    = p1_we_in;
    assign in_valid[0] = p0_valid_in;
    assign in_valid[1] = p1_valid_in;

    assign p0_ready_out = fifo_rdy[0];
    assign p1_ready_out = fifo_rdy[1];
    assign p0_addr_out  = rsp_addr;
    assign p1_addr_out  = rsp_addr;
    assign p0_value_out = rsp_value;
    assign p1_value_out = rsp_value;

    // FIFO occupancy, ready (held low while in reset) and push qualification
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            count[i]    = wr_ptr[i] - rd_ptr[i];
            nempty[i]   = (count[i] != '0);
            fifo_rdy[i] = !rst_in && (count[i] != FULL_CNT);
            push[i]     = in_valid[i] && fifo_rdy[i];
        end
    end

    // FIFO pointers; wrap modulo 2*DEPTH through the extra MSB
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care until pushed
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem_addr[i][wr_ptr[i][AW-1:0]]  <= in_addr[i];
                mem_value[i][wr_ptr[i][AW-1:0]] <= in_value[i];
                mem_we[i][wr_ptr[i][AW-1:0]]    <= in_we[i];
            end
        end
    end

    // next-state, round-robin grant and FIFO pop
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        grant    = 1'b0;
        gnt_port = 1'b0;
        unique case (state)
            IDLE: begin
                if (nempty[0] || nempty[1]) begin
                    grant    = 1'b1;
                    gnt_port = (nempty[0] && nempty[1]) ? !last_grant : nempty[1];
                    owner_nx = gnt_port;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (hc_ready_in)
                    state_nx = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (hc_valid_in)
                    state_nx = RETURN;
            end
            RETURN: begin
                if (owner ? p1_ready_in : p0_ready_in)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        pop[0] = grant && !gnt_port;
        pop[1] = grant && gnt_port;
    end

    // state, issue/response registers and registered handshake outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            hc_addr_out  <= '0;
            hc_value_out <= '0;
            hc_we_out    <= 1'b0;
            rsp_addr     <= '0;
            rsp_value    <= '0;
            hc_valid_out <= 1'b0;
            hc_ready_out <= 1'b0;
            p0_valid_out <= 1'b0;
            p1_valid_out <= 1'b0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            if (grant) begin
                last_grant   <= gnt_port;
                hc_addr_out  <= mem_addr[gnt_port][rd_ptr[gnt_port][AW-1:0]];
                hc_value_out <= mem_value[gnt_port][rd_ptr[gnt_port][AW-1:0]];
                hc_we_out    <= mem_we[gnt_port][rd_ptr[gnt_port][AW-1:0]];
            end
            if (state == WAIT_RSP && hc_valid_in) begin
                rsp_addr  <= hc_addr_in;
                rsp_value <= hc_value_in;
            end
            hc_valid_out <= (state_nx == ISSUE);
            hc_ready_out <= (state_nx == WAIT_RSP);
            p0_valid_out <= (state_nx == RETURN) && !owner_nx;
            p1_valid_out <= (state_nx == RETURN) && owner_nx;
        end
    end

`ifdef LLC_ARB_STATS_EN
    // per-port grant counters, wrapping at 2^32
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            p0_grants_out <= '0;
            p1_grants_out <= '0;
        end else if (grant) begin
            if (gnt_port)
                p1_grants_out <= p1_grants_out + 32'd1;
            else
                p0_grants_out <= p0_grants_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_llc_hc_arbiter.sv
// tb_llc_hc_arbiter: scoreboard bench for llc_hc_arbiter with a simple LLC model.
// Build with LLC_ARB_STATS_EN to also exercise the grant counters.

module tb_llc_hc_arbiter;

    localparam int PB = 19;
    localparam int W  = 64;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          p0_valid_in, p0_ready_out, p0_we_in;
    logic [PB-1:0] p0_addr_in;
    logic [W-1:0]  p0_value_in;
    logic          p1_valid_in, p1_ready_out, p1_we_in;
    logic [PB-1:0] p1_addr_in;
    logic [W-1:0]  p1_value_in;
    logic          p0_valid_out, p0_ready_in;
    logic [PB-1:0] p0_addr_out;
    logic [W-1:0]  p0_value_out;
    logic          p1_valid_out, p1_ready_in;
    logic [PB-1:0] p1_addr_out;
    logic [W-1:0]  p1_value_out;
    logic          hc_valid_out, hc_ready_in, hc_we_out;
    logic [PB-1:0] hc_addr_out;
    logic [W-1:0]  hc_value_out;
    logic          hc_valid_in, hc_ready_out;
    logic [PB-1:0] hc_addr_in;
    logic [W-1:0]  hc_value_in;
`ifdef LLC_ARB_STATS_EN
    logic [31:0]   p0_grants_out, p1_grants_out;
`endif

    always #5 clk_in = ~clk_in;

    llc_hc_arbiter #(.PADDR_BITS(PB), .W(W), .DEPTH(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .p0_valid_in(p0_valid_in), .p0_ready_out(p0_ready_out),
        .p0_addr_in(p0_addr_in), .p0_value_in(p0_value_in), .p0_we_in(p0_we_in),
        .p1_valid_in(p1_valid_in), .p1_ready_out(p1_ready_out),
        .p1_addr_in(p1_addr_in), .p1_value_in(p1_value_in), .p1_we_in(p1_we_in),
        .p0_valid_out(p0_valid_out), .p0_ready_in(p0_ready_in),
        .p0_addr_out(p0_addr_out), .p0_value_out(p0_value_out),
        .p1_valid_out(p1_valid_out), .p1_ready_in(p1_ready_in),
        .p1_addr_out(p1_addr_out), .p1_value_out(p1_value_out),
        .hc_valid_out(hc_valid_out), .hc_ready_in(hc_ready_in),
        .hc_addr_out(hc_addr_out), .hc_value_out(hc_value_out), .hc_we_out(hc_we_out),
        .hc_valid_in(hc_valid_in), .hc_ready_out(hc_ready_out),
        .hc_addr_in(hc_addr_in), .hc_value_in(hc_value_in)
`ifdef LLC_ARB_STATS_EN
        ,
        .p0_grants_out(p0_grants_out), .p1_grants_out(p1_grants_out)
`endif
    );

    typedef struct {
        logic [PB-1:0] addr;
        logic [W-1:0]  value;
        logic          we;
    } req_t;

    typedef struct {
        logic [PB-1:0] addr;
        logic [W-1:0]  value;
    } rsp_t;

    req_t         exp_req[$];
    rsp_t         exp_rsp0[$];
    rsp_t         exp_rsp1[$];
    logic [W-1:0] llc_val_q[$];
    logic         llc_hold = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic expect_txn(input int port, input logic [PB-1:0] a,
                              input logic [W-1:0] v, input logic we,
                              input logic [W-1:0] lv);
        exp_req.push_back(req_t'{a, v, we});
        llc_val_q.push_back(lv);
        if (port == 0)
            exp_rsp0.push_back(rsp_t'{a, lv});
        else
            exp_rsp1.push_back(rsp_t'{a, lv});
    endtask

    task automatic push(input int port, input logic [PB-1:0] a, input logic [W-1:0] v,
                        input logic we, input int budget, output bit acc);
        acc = 1'b0;
        if (port == 0) begin
            p0_valid_in = 1'b1; p0_addr_in = a; p0_value_in = v; p0_we_in = we;
        end else begin
            p1_valid_in = 1'b1; p1_addr_in = a; p1_value_in = v; p1_we_in = we;
        end
        for (int k = 0; k < budget && !acc; k++) begin
            @(negedge clk_in);
            acc = (port == 0) ? p0_ready_out : p1_ready_out;
            @(posedge clk_in);
            #1;
        end
        if (port == 0) p0_valid_in = 1'b0;
        else           p1_valid_in = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 500; k++) begin
            if (exp_req.size() + exp_rsp0.size() + exp_rsp1.size() == 0)
                break;
            cyc(1);
        end
        chk(name, exp_req.size() + exp_rsp0.size() + exp_rsp1.size(), 0);
    endtask

    task automatic do_reset;
        rst_in      = 1'b1;
        p0_valid_in = 1'b0;
        p1_valid_in = 1'b0;
        p0_ready_in = 1'b1;
        p1_ready_in = 1'b1;
        hc_ready_in = 1'b1;
        llc_hold    = 1'b0;
        exp_req.delete();
        exp_rsp0.delete();
        exp_rsp1.delete();
        llc_val_q.delete();
        cyc(2);
        rst_in = 1'b0;
        cyc(1);
    endtask

    // LLC model: answer each accepted request once, echoing its address
    initial begin : llc_model
        logic [PB-1:0] a;
        logic [W-1:0]  v;
        hc_valid_in = 1'b0;
        hc_addr_in  = '0;
        hc_value_in = '0;
        forever begin
            @(negedge clk_in);
            if (!rst_in && hc_valid_out && hc_ready_in) begin
                a = hc_addr_out;
                v = (llc_val_q.size() != 0) ? llc_val_q.pop_front() : 64'hBAD;
                @(posedge clk_in);
                #1;
                for (int k = 0; k < 2000 && llc_hold && !rst_in; k++) begin
                    @(posedge clk_in);
                    #1;
                end
                if (!rst_in) begin
                    hc_valid_in = 1'b1;
                    hc_addr_in  = a;
                    hc_value_in = v;
                    for (int k = 0; k < 50; k++) begin
                        @(negedge clk_in);
                        if (hc_ready_out || rst_in)
                            break;
                    end
                    @(posedge clk_in);
                    #1;
                    hc_valid_in = 1'b0;
                end
            end
        end
    end

    // scoreboard monitor: compare every handshake against the queues
    always @(negedge clk_in) begin : monitor
        req_t e;
        rsp_t r;
        if (!rst_in) begin
            if (hc_valid_out && hc_ready_in) begin
                if (exp_req.size() == 0) begin
                    chk("unexpected_req", hc_addr_out, 'x);
                end else begin
                    e = exp_req.pop_front();
                    chk("req_addr", hc_addr_out, e.addr);
                    chk("req_value", hc_value_out, e.value);
                    chk("req_we", hc_we_out, e.we);
                end
            end
            if (p0_valid_out && p0_ready_in) begin
                if (exp_rsp0.size() == 0) begin
                    chk("unexpected_rsp0", p0_addr_out, 'x);
                end else begin
                    r = exp_rsp0.pop_front();
                    chk("rsp0_addr", p0_addr_out, r.addr);
                    chk("rsp0_value", p0_value_out, r.value);
                end
            end
            if (p1_valid_out && p1_ready_in) begin
                if (exp_rsp1.size() == 0) begin
                    chk("unexpected_rsp1", p1_addr_out, 'x);
                end else begin
                    r = exp_rsp1.pop_front();
                    chk("rsp1_addr", p1_addr_out, r.addr);
                    chk("rsp1_value", p1_value_out, r.value);
                end
            end
            if (p0_valid_out || p1_valid_out)
                chk("rsp_exclusive", {hc_valid_out, p0_valid_out & p1_valid_out}, 2'b00);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        bit acc;
        bit seen;
        p0_valid_in = 0; p0_addr_in = '0; p0_value_in = '0; p0_we_in = 0;
        p1_valid_in = 0; p1_addr_in = '0; p1_value_in = '0; p1_we_in = 0;
        p0_ready_in = 1; p1_ready_in = 1; hc_ready_in = 1;

        // reset state
        #1;
        chk("rst_hc_valid", hc_valid_out, 0);
        chk("rst_hc_ready", hc_ready_out, 0);
        chk("rst_p0_valid", p0_valid_out, 0);
        chk("rst_p1_valid", p1_valid_out, 0);
        chk("rst_p0_ready_in_reset", p0_ready_out, 0);
        cyc(2);
        rst_in = 1'b0;
        cyc(1);
        chk("rst_p0_ready", p0_ready_out, 1);
        chk("rst_p1_ready", p1_ready_out, 1);

        // single read with latency check
        expect_txn(0, 19'h00100, 64'h0, 1'b0, 64'hDEADBEEF);
        push(0, 19'h00100, 64'h0, 1'b0, 20, acc);
        chk("t1_accept", acc, 1);
        chk("t1_lat_edge_n", hc_valid_out, 0);
        cyc(1);
        chk("t1_lat_edge_n1", hc_valid_out, 1);
        chk("t1_addr", hc_addr_out, 19'h00100);
        chk("t1_we", hc_we_out, 0);
        drain("t1_drain");

        // simultaneous requests after reset: port 0 wins the first tie
        do_reset();
        expect_txn(0, 19'h00040, 64'h0, 1'b0, 64'hA1);
        expect_txn(1, 19'h00080, 64'h1234, 1'b1, 64'hB2);
        p0_valid_in = 1; p0_addr_in = 19'h00040; p0_value_in = '0; p0_we_in = 0;
        p1_valid_in = 1; p1_addr_in = 19'h00080; p1_value_in = 64'h1234; p1_we_in = 1;
        @(negedge clk_in);
        chk("t2_ready_both", {p0_ready_out, p1_ready_out}, 2'b11);
        @(posedge clk_in);
        #1;
        p0_valid_in = 0;
        p1_valid_in = 0;
        drain("t2_drain");

        // FIFO full under LLC stall
        do_reset();
        hc_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_txn(1, 19'h00200 + 19'(8 * i), 64'h100 + 64'(i), i[0], 64'h5000 + 64'(i));
            push(1, 19'h00200 + 19'(8 * i), 64'h100 + 64'(i), i[0], 5, acc);
            chk("t3_accept", acc, 1);
            chk("t3_ready", p1_ready_out, (i < 4));
        end
        push(1, 19'h002F0, 64'hEE, 1'b0, 4, acc);
        chk("t3_full_reject", acc, 0);
        chk("t3_stall_valid", hc_valid_out, 1);
        chk("t3_stall_addr", hc_addr_out, 19'h00200);
        hc_ready_in = 1'b1;
        drain("t3_drain");

        // response backpressure on port 0 with port 1 pending
        do_reset();
        p0_ready_in = 1'b0;
        expect_txn(0, 19'h00300, 64'h0, 1'b0, 64'hCAFE0004);
        expect_txn(1, 19'h00308, 64'h77, 1'b1, 64'h99);
        push(0, 19'h00300, 64'h0, 1'b0, 20, acc);
        push(1, 19'h00308, 64'h77, 1'b1, 20, acc);
        for (int k = 0; k < 50 && !p0_valid_out; k++)
            cyc(1);
        chk("t4_rsp_valid", p0_valid_out, 1);
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            chk("t4_hold_valid", p0_valid_out, 1);
            chk("t4_hold_value", p0_value_out, 64'hCAFE0004);
            chk("t4_no_issue", hc_valid_out, 0);
            chk("t4_p1_idle", p1_valid_out, 0);
        end
        p0_ready_in = 1'b1;
        drain("t4_drain");

        // reset while waiting for the LLC response
        do_reset();
        llc_hold = 1'b1;
        expect_txn(0, 19'h00400, 64'h0, 1'b0, 64'h1);
        push(0, 19'h00400, 64'h0, 1'b0, 20, acc);
        push(1, 19'h00408, 64'h5, 1'b1, 20, acc);
        for (int k = 0; k < 50 && !hc_ready_out; k++)
            cyc(1);
        chk("t5_in_wait", hc_ready_out, 1);
        rst_in = 1'b1;
        #1;
        chk("t5_hc_ready", hc_ready_out, 0);
        chk("t5_hc_addr", hc_addr_out, 0);
        chk("t5_hc_we_valid", {hc_we_out, hc_valid_out}, 2'b00);
        chk("t5_p_valid", {p0_valid_out, p1_valid_out}, 2'b00);
        chk("t5_p0_value", p0_value_out, 0);
        chk("t5_p_ready", {p0_ready_out, p1_ready_out}, 2'b00);
        exp_req.delete();
        exp_rsp0.delete();
        exp_rsp1.delete();
        llc_val_q.delete();
        llc_hold = 1'b0;
        cyc(2);
        rst_in = 1'b0;
        cyc(1);
        chk("t5_ready_after", {p0_ready_out, p1_ready_out}, 2'b11);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            if (hc_valid_out)
                seen = 1'b1;
        end
        chk("t5_fifos_empty", seen, 0);

`ifdef LLC_ARB_STATS_EN
        // grant counters under alternating load
        do_reset();
        chk("t6_rst_grants", {p0_grants_out, p1_grants_out}, 64'h0);
        for (int i = 0; i < 5; i++) begin
            expect_txn(i % 2, 19'h00500 + 19'(i), 64'h0, 1'b0, 64'h600 + 64'(i));
            push(i % 2, 19'h00500 + 19'(i), 64'h0, 1'b0, 20, acc);
            drain("t6_drain");
        end
        chk("t6_p0_grants", p0_grants_out, 3);
        chk("t6_p1_grants", p1_grants_out, 2);
`endif

        cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
